// File: rtl/sha3_pkg.sv
// Shared Keccak-f[1600] types, rho offsets, pi source map and rotate helper.
// Used by the theta, rho_pi and chi round blocks.
package sha3_pkg;

  localparam int LANE_W = 64;
  localparam int LANES  = 25;

  typedef logic [LANE_W-1:0] lane_t;

  // rho rotation amount, indexed by input lane x+5y
  localparam int RHO_OFS [LANES] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14
  };

  // pi: input lane feeding each output lane
  localparam int PI_SRC [LANES] = '{
     0,  6, 12, 18, 24,
     3,  9, 10, 16, 22,
     1,  7, 13, 19, 20,
     4,  5, 11, 17, 23,
     2,  8, 14, 15, 21
  };

  function automatic lane_t rotl(lane_t v, int n);
    if (n == 0) return v;
    return (v << n) | (v >> (LANE_W - n));
  endfunction

endpackage

// File: rtl/rho_pi_lane.sv
// Constant left-rotate of one 64-bit Keccak lane.
// Pure wiring; SHIFT is fixed at elaboration.
module rho_pi_lane
  import sha3_pkg::*;
#(
  parameter int SHIFT = 0
) (
  input  lane_t a,
  output lane_t y
);

  assign y = rotl(a, SHIFT);

endmodule

// File: rtl/rho_pi.sv
// Registered Keccak rho+pi step. Define RHO_PI_INREG_EN to add an
// input register stage (latency 2 instead of 1).
module rho_pi
  import sha3_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [63:0] in_data_0,
  input  logic [63:0] in_data_1,
  input  logic [63:0] in_data_2,
  input  logic [63:0] in_data_3,
  input  logic [63:0] in_data_4,
  input  logic [63:0] in_data_5,
  input  logic [63:0] in_data_6,
  input  logic [63:0] in_data_7,
  input  logic [63:0] in_data_8,
  input  logic [63:0] in_data_9,
  input  logic [63:0] in_data_10,
  input  logic [63:0] in_data_11,
  input  logic [63:0] in_data_12,
  input  logic [63:0] in_data_13,
  input  logic [63:0] in_data_14,
  input  logic [63:0] in_data_15,
  input  logic [63:0] in_data_16,
  input  logic [63:0] in_data_17,
  input  logic [63:0] in_data_18,
  input  logic [63:0] in_data_19,
  input  logic [63:0] in_data_20,
  input  logic [63:0] in_data_21,
  input  logic [63:0] in_data_22,
  input  logic [63:0] in_data_23,
  input  logic [63:0] in_data_24,
  output logic        out_valid,
  output logic [63:0] out_data_0,
  output logic [63:0] out_data_1,
  output logic [63:0] out_data_2,
  output logic [63:0] out_data_3,
  output logic [63:0] out_data_4,
  output logic [63:0] out_data_5,
  output logic [63:0] out_data_6,
  output logic [63:0] out_data_7,
  output logic [63:0] out_data_8,
  output logic [63:0] out_data_9,
  output logic [63:0] out_data_10,
  output logic [63:0] out_data_11,
  output logic [63:0] out_data_12,
  output logic [63:0] out_data_13,
  output logic [63:0] out_data_14,
  output logic [63:0] out_data_15,
  output logic [63:0] out_data_16,
  output logic [63:0] out_data_17,
  output logic [63:0] out_data_18,
  output logic [63:0] out_data_19,
  output logic [63:0] out_data_20,
  output logic [63:0] out_data_21,
  output logic [63:0] out_data_22,
  output logic [63:0] out_data_23,
  output logic [63:0] out_data_24
);

  lane_t din  [LANES];
  lane_t src  [LANES];
  lane_t rot  [LANES];
  lane_t dout [LANES];
  logic  ld;

  assign din = '{
    in_data_0,  in_data_1,  in_data_2,
    in_data_3,  in_data_4,  in_data_5,
    in_data_6,  in_data_7,  in_data_8,
    in_data_9,  in_data_10, in_data_11,
    in_data_12, in_data_13, in_data_14,
    in_data_15, in_data_16, in_data_17,
    in_data_18, in_data_19, in_data_20,
    in_data_21, in_data_22, in_data_23,
    in_data_24
  };

`ifdef RHO_PI_INREG_EN
  lane_t sreg [LANES];
  logic  sval;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sval <= 1'b0;
      for (int i = 0; i < LANES; i++) sreg[i] <= '0;
    end else begin
      sval <= in_valid;
      if (in_valid)
        for (int i = 0; i < LANES; i++) sreg[i] <= din[i];
    end
  end

  assign src = sreg;
  assign ld  = sval;
`else
  assign src = din;
  assign ld  = in_valid;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    rho_pi_lane #(
      .SHIFT(RHO_OFS[PI_SRC[i]])
    ) u_lane (
      .a(src[PI_SRC[i]]),
      .y(rot[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      for (int i = 0; i < LANES; i++) dout[i] <= '0;
    end else begin
      out_valid <= ld;
      if (ld)
        for (int i = 0; i < LANES; i++) dout[i] <= rot[i];
    end
  end

  assign out_data_0  = dout[0];
  assign out_data_1  = dout[1];
  assign out_data_2  = dout[2];
  assign out_data_3  = dout[3];
  assign out_data_4  = dout[4];
  assign out_data_5  = dout[5];
  assign out_data_6  = dout[6];
  assign out_data_7  = dout[7];
  assign out_data_8  = dout[8];
  assign out_data_9  = dout[9];
  assign out_data_10 = dout[10];
  assign out_data_11 = dout[11];
  assign out_data_12 = dout[12];
  assign out_data_13 = dout[13];
  assign out_data_14 = dout[14];
  assign out_data_15 = dout[15];
  assign out_data_16 = dout[16];
  assign out_data_17 = dout[17];
  assign out_data_18 = dout[18];
  assign out_data_19 = dout[19];
  assign out_data_20 = dout[20];
  assign out_data_21 = dout[21];
  assign out_data_22 = dout[22];
  assign out_data_23 = dout[23];
  assign out_data_24 = dout[24];

endmodule

// File: tb/tb_rho_pi.sv
// Directed and random-stream bench for rho_pi.
// Honours RHO_PI_INREG_EN for the expected latency.
module tb_rho_pi;

`ifdef RHO_PI_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef logic [25*64-1:0] flat_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_valid;
  logic [63:0] di [25];
  logic [63:0] dq [25];

  int checks;
  int errors;

  rho_pi dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_data_0(di[0]),   .in_data_1(di[1]),   .in_data_2(di[2]),
    .in_data_3(di[3]),   .in_data_4(di[4]),   .in_data_5(di[5]),
    .in_data_6(di[6]),   .in_data_7(di[7]),   .in_data_8(di[8]),
    .in_data_9(di[9]),   .in_data_10(di[10]), .in_data_11(di[11]),
    .in_data_12(di[12]), .in_data_13(di[13]), .in_data_14(di[14]),
    .in_data_15(di[15]), .in_data_16(di[16]), .in_data_17(di[17]),
    .in_data_18(di[18]), .in_data_19(di[19]), .in_data_20(di[20]),
    .in_data_21(di[21]), .in_data_22(di[22]), .in_data_23(di[23]),
    .in_data_24(di[24]),
    .out_valid(out_valid),
    .out_data_0(dq[0]),   .out_data_1(dq[1]),   .out_data_2(dq[2]),
    .out_data_3(dq[3]),   .out_data_4(dq[4]),   .out_data_5(dq[5]),
    .out_data_6(dq[6]),   .out_data_7(dq[7]),   .out_data_8(dq[8]),
    .out_data_9(dq[9]),   .out_data_10(dq[10]), .out_data_11(dq[11]),
    .out_data_12(dq[12]), .out_data_13(dq[13]), .out_data_14(dq[14]),
    .out_data_15(dq[15]), .out_data_16(dq[16]), .out_data_17(dq[17]),
    .out_data_18(dq[18]), .out_data_19(dq[19]), .out_data_20(dq[20]),
    .out_data_21(dq[21]), .out_data_22(dq[22]), .out_data_23(dq[23]),
    .out_data_24(dq[24])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference built from the Keccak definition: offsets from the
  // triangular-number walk, positions from the pi index rule.
  function automatic flat_t model(flat_t s);
    int r [5][5];
    int x, y, nx, sx, sy, n;
    logic [63:0] v, o;
    flat_t res;
    r[0][0] = 0;
    x = 1; y = 0;
    for (int t = 0; t < 24; t++) begin
      r[x][y] = ((t + 1) * (t + 2) / 2) % 64;
      nx = y;
      y = (2 * x + 3 * y) % 5;
      x = nx;
    end
    res = '0;
    for (int ox = 0; ox < 5; ox++)
      for (int oy = 0; oy < 5; oy++) begin
        sx = (ox + 3 * oy) % 5;
        sy = ox;
        v = s[(sx + 5 * sy) * 64 +: 64];
        n = r[sx][sy];
        o = (n == 0) ? v : ((v << n) | (v >> (64 - n)));
        res[(ox + 5 * oy) * 64 +: 64] = o;
      end
    return res;
  endfunction

  function automatic flat_t pack_in();
    flat_t f;
    for (int i = 0; i < 25; i++) f[i * 64 +: 64] = di[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_in();
    for (int i = 0; i < 25; i++) di[i] = '0;
  endtask

  // One nonzero input lane; expect one nonzero output lane.
  task automatic walk(input int il, input logic [63:0] iv,
                      input int ol, input logic [63:0] ov);
    zero_in();
    di[il] = iv;
    in_valid = 1'b1;
    repeat (LAT) tick();
    chk($sformatf("walk%0d_vld", il), {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 25; i++)
      chk($sformatf("walk%0d_o%0d", il, i), dq[i],
          (i == ol) ? ov : 64'd0);
  endtask

  flat_t q [$];
  flat_t e;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 25; i++) di[i] = {$urandom, $urandom};

    repeat (3) tick();
    chk("rst_vld", {63'd0, out_valid}, 64'd0);
    for (int i = 0; i < 25; i++)
      chk($sformatf("rst_o%0d", i), dq[i], 64'd0);

    rst_n = 1'b1;
    repeat (LAT) tick();
    chk("rel_vld", {63'd0, out_valid}, 64'd1);

    walk(1,  64'h1, 10, 64'h2);
    walk(6,  64'h1, 1,  64'h0000100000000000);
    walk(2,  64'h1, 20, 64'h4000000000000000);
    walk(2,  64'h8000000000000001, 20, 64'h6000000000000000);
    walk(24, 64'hFFFF000000000000, 4,  64'hC000000000003FFF);
    walk(0,  64'h0123456789ABCDEF, 0,  64'h0123456789ABCDEF);
    walk(15, 64'h1, 23, 64'h0000020000000000);

    for (int i = 0; i < 25; i++) di[i] = '1;
    repeat (LAT) tick();
    for (int i = 0; i < 25; i++)
      chk($sformatf("ones_o%0d", i), dq[i], '1);

    zero_in();
    repeat (LAT) tick();
    for (int i = 0; i < 25; i++)
      chk($sformatf("zero_o%0d", i), dq[i], 64'd0);

    for (int k = 0; k < 1000 + LAT - 1; k++) begin
      if (k < 1000) begin
        for (int i = 0; i < 25; i++) di[i] = {$urandom, $urandom};
        in_valid = 1'b1;
        q.push_back(model(pack_in()));
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (k >= LAT - 1) begin
        e = q.pop_front();
        chk($sformatf("strm%0d_vld", k), {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 25; i++)
          chk($sformatf("strm%0d_o%0d", k, i), dq[i], e[i * 64 +: 64]);
      end
    end

    in_valid = 1'b0;
    for (int i = 0; i < 25; i++) di[i] = {$urandom, $urandom};
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("hold%0d_vld", c), {63'd0, out_valid}, 64'd0);
      for (int i = 0; i < 25; i++)
        chk($sformatf("hold%0d_o%0d", c, i), dq[i], e[i * 64 +: 64]);
    end

    in_valid = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_vld", {63'd0, out_valid}, 64'd0);
    for (int i = 0; i < 25; i++)
      chk($sformatf("async_o%0d", i), dq[i], 64'd0);
    tick();
    rst_n = 1'b1;
    walk(2, 64'h1, 20, 64'h4000000000000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
